// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: round-robin arbiter sharing one cacheline memory port
// between the I-cache and D-cache. The winning request is latched and held
// on the memory port until mem_resp, and the response goes back to the winner.
module cacheline_arbiter #(
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [31:0]       i_dfp_addr,
    input  logic              i_dfp_read,
    input  logic              i_dfp_write,
    input  logic [LINE_W-1:0] i_dfp_wdata,
    output logic [LINE_W-1:0] i_dfp_rdata,
    output logic              i_dfp_resp,

    input  logic [31:0]       d_dfp_addr,
    input  logic              d_dfp_read,
    input  logic              d_dfp_write,
    input  logic [LINE_W-1:0] d_dfp_wdata,
    output logic [LINE_W-1:0] d_dfp_rdata,
    output logic              d_dfp_resp,

    output logic [31:0]       mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned OFFSET_W = 5;

    // Clears the byte offset within a line; the full address is consumed so
    // every input bit has a defined use.
    localparam logic [ADDR_W-1:0] LINE_MASK =
        {{(ADDR_W - OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef enum logic {
        s_idle = 1'b0,
        s_busy = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic                req_read_q, req_read_d;
    logic                req_write_q, req_write_d;
    logic [LINE_W-1:0]   req_wdata_q, req_wdata_d;

    logic                i_pend;
    logic                d_pend;
    logic                winner;
    logic                i_resp_c;
    logic                d_resp_c;

    // Pending detection and round-robin winner selection.
    always_comb begin
        i_pend = i_dfp_read | i_dfp_write;
        d_pend = d_dfp_read | d_dfp_write;
        winner = GRANT_I;
        if (i_pend && d_pend) begin
            winner = ~last_grant_q;
        end else if (d_pend) begin
            winner = GRANT_D;
        end
    end

    // Next-state, request latching and response routing.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        req_addr_d   = req_addr_q;
        req_read_d   = req_read_q;
        req_write_d  = req_write_q;
        req_wdata_d  = req_wdata_q;
        i_resp_c     = 1'b0;
        d_resp_c     = 1'b0;

        unique case (state_q)
            s_idle: begin
                if (i_pend || d_pend) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    state_d      = s_busy;
                    // Write has priority when a cache raises both strobes.
                    if (winner == GRANT_D) begin
                        req_addr_d  = d_dfp_addr & LINE_MASK;
                        req_write_d = d_dfp_write;
                        req_read_d  = d_dfp_read & ~d_dfp_write;
                        req_wdata_d = d_dfp_wdata;
                    end else begin
                        req_addr_d  = i_dfp_addr & LINE_MASK;
                        req_write_d = i_dfp_write;
                        req_read_d  = i_dfp_read & ~i_dfp_write;
                        req_wdata_d = i_dfp_wdata;
                    end
                end
            end
            s_busy: begin
                if (mem_resp) begin
                    if (grant_q == GRANT_D) begin
                        d_resp_c = 1'b1;
                    end else begin
                        i_resp_c = 1'b1;
                    end
                    req_read_d  = 1'b0;
                    req_write_d = 1'b0;
                    state_d     = s_idle;
                end
            end
            default: begin
                state_d = s_idle;
            end
        endcase
    end

    // State and request registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= s_idle;
            grant_q      <= GRANT_I;
            last_grant_q <= GRANT_I;
            req_addr_q   <= '0;
            req_read_q   <= 1'b0;
            req_write_q  <= 1'b0;
            req_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            req_addr_q   <= req_addr_d;
            req_read_q   <= req_read_d;
            req_write_q  <= req_write_d;
            req_wdata_q  <= req_wdata_d;
        end
    end

    // Memory port comes straight from the latched request.
    assign mem_addr    = req_addr_q;
    assign mem_read    = req_read_q;
    assign mem_write   = req_write_q;
    assign mem_wdata   = req_wdata_q;

    // Completion and read data pass through in the mem_resp cycle.
    assign i_dfp_resp  = i_resp_c;
    assign d_dfp_resp  = d_resp_c;
    assign i_dfp_rdata = mem_rdata;
    assign d_dfp_rdata = mem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: directed plus random traffic against a transaction-level
// reference model of the arbiter.
module tb_cacheline_arbiter;

    localparam int unsigned LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       i_dfp_addr, d_dfp_addr;
    logic              i_dfp_read, i_dfp_write, d_dfp_read, d_dfp_write;
    logic [LINE_W-1:0] i_dfp_wdata, d_dfp_wdata;
    logic [LINE_W-1:0] i_dfp_rdata, d_dfp_rdata;
    logic              i_dfp_resp, d_dfp_resp;
    logic [31:0]       mem_addr;
    logic              mem_read, mem_write;
    logic [LINE_W-1:0] mem_wdata, mem_rdata;
    logic              mem_resp;

    cacheline_arbiter #(.LINE_W(LINE_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_dfp_addr  (i_dfp_addr),
        .i_dfp_read  (i_dfp_read),
        .i_dfp_write (i_dfp_write),
        .i_dfp_wdata (i_dfp_wdata),
        .i_dfp_rdata (i_dfp_rdata),
        .i_dfp_resp  (i_dfp_resp),
        .d_dfp_addr  (d_dfp_addr),
        .d_dfp_read  (d_dfp_read),
        .d_dfp_write (d_dfp_write),
        .d_dfp_wdata (d_dfp_wdata),
        .d_dfp_rdata (d_dfp_rdata),
        .d_dfp_resp  (d_dfp_resp),
        .mem_addr    (mem_addr),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: one outstanding transaction, owner 0 = I, 1 = D.
    bit          m_busy  = 1'b0;
    int          m_owner = 0;
    int          m_last  = 0;
    bit          m_fresh = 1'b1;
    logic        m_rd    = 1'b0;
    logic        m_wr    = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [LINE_W-1:0] m_wd = '0;

    bit i_resp_s = 1'b0;
    bit d_resp_s = 1'b0;
    int order[$];

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Advance the model by one accepted clock edge using the sampled inputs.
    task automatic model_edge();
        bit pi, pd;
        int w;
        if (rst) begin
            m_busy = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
            m_addr = '0;   m_wd = '0;   m_last = 0; m_fresh = 1'b1;
        end else if (m_busy) begin
            if (mem_resp) begin
                m_busy = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
            end
        end else begin
            pi = i_dfp_read || i_dfp_write;
            pd = d_dfp_read || d_dfp_write;
            if (pi || pd) begin
                if (pi && pd) w = 1 - m_last;
                else          w = pd ? 1 : 0;
                if (w == 1) begin
                    m_addr = {d_dfp_addr[31:5], 5'b0};
                    m_wr = d_dfp_write; m_rd = d_dfp_read && !d_dfp_write;
                    m_wd = d_dfp_wdata;
                end else begin
                    m_addr = {i_dfp_addr[31:5], 5'b0};
                    m_wr = i_dfp_write; m_rd = i_dfp_read && !i_dfp_write;
                    m_wd = i_dfp_wdata;
                end
                m_owner = w; m_last = w; m_busy = 1'b1; m_fresh = 1'b0;
            end
        end
    endtask

    // One clock: check outputs mid-cycle, then take the edge.
    task automatic cyc();
        logic exp_ir, exp_dr;
        @(negedge clk);
        exp_ir = m_busy && (m_owner == 0) && mem_resp;
        exp_dr = m_busy && (m_owner == 1) && mem_resp;
        chk("mem_read", mem_read, m_rd);
        chk("mem_write", mem_write, m_wr);
        chk("i_resp", i_dfp_resp, exp_ir);
        chk("d_resp", d_dfp_resp, exp_dr);
        if (m_busy || m_fresh) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wd);
        end
        if (exp_ir) chk("i_rdata", i_dfp_rdata, mem_rdata);
        if (exp_dr) chk("d_rdata", d_dfp_rdata, mem_rdata);
        i_resp_s = i_dfp_resp;
        d_resp_s = d_dfp_resp;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        i_dfp_read = 0; i_dfp_write = 0; d_dfp_read = 0; d_dfp_write = 0;
        i_dfp_addr = '0; d_dfp_addr = '0; i_dfp_wdata = '0; d_dfp_wdata = '0;
        mem_resp = 0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_i_resp", i_dfp_resp, 1'b0);
        chk("rst_d_resp", d_dfp_resp, 1'b0);
        i_resp_s = 1'b0;
        d_resp_s = 1'b0;
    endtask

    // Protocol-following caches and a variable-latency memory.
    task automatic run_traffic(input int ncyc, input bit always_req, input int max_lat);
        int cnt;
        int lat;
        int op;
        int served_other[2];
        cnt = 0;
        lat = $urandom_range(1, max_lat);
        served_other[0] = 0;
        served_other[1] = 0;
        for (int n = 0; n < ncyc; n++) begin
            if (i_resp_s) begin
                i_dfp_read = 0; i_dfp_write = 0;
            end else if (!(i_dfp_read || i_dfp_write) &&
                         (always_req || $urandom_range(0, 3) == 0)) begin
                op = $urandom_range(0, 2);
                i_dfp_addr = $urandom();
                i_dfp_read = (op != 1); i_dfp_write = (op != 0);
                i_dfp_wdata = rand_line();
            end
            if (d_resp_s) begin
                d_dfp_read = 0; d_dfp_write = 0;
            end else if (!(d_dfp_read || d_dfp_write) &&
                         (always_req || $urandom_range(0, 3) == 0)) begin
                op = $urandom_range(0, 2);
                d_dfp_addr = $urandom();
                d_dfp_read = (op != 1); d_dfp_write = (op != 0);
                d_dfp_wdata = rand_line();
            end
            if (mem_resp) begin
                mem_resp = 0;
                cnt = 0;
            end else if (mem_read || mem_write) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_resp = 1;
                    mem_rdata = rand_line();
                    lat = $urandom_range(1, max_lat);
                end
            end else begin
                mem_resp = ($urandom_range(0, 15) == 0);
                mem_rdata = rand_line();
            end
            cyc();
            if (d_resp_s && (i_dfp_read || i_dfp_write)) served_other[0]++;
            if (i_resp_s && (d_dfp_read || d_dfp_write)) served_other[1]++;
            if (i_resp_s) begin
                order.push_back(0);
                chk("i_wait_bound", 32'(served_other[0] <= 1), 32'd1);
                served_other[0] = 0;
            end
            if (d_resp_s) begin
                order.push_back(1);
                chk("d_wait_bound", 32'(served_other[1] <= 1), 32'd1);
                served_other[1] = 0;
            end
        end
    endtask

    initial begin
        logic [LINE_W-1:0] a5;
        a5 = {32{8'hA5}};
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // Single I read.
        i_dfp_addr = 32'h1234_5678; i_dfp_read = 1;
        cyc();
        chk("t1_mem_read", mem_read, 1'b1);
        chk("t1_mem_addr", mem_addr, 32'h1234_5660);
        cyc();
        cyc();
        mem_resp = 1; mem_rdata = a5;
        #1;
        chk("t1_i_resp", i_dfp_resp, 1'b1);
        chk("t1_i_rdata", i_dfp_rdata, a5);
        chk("t1_d_resp", d_dfp_resp, 1'b0);
        cyc();
        i_dfp_read = 0; mem_resp = 0;
        cyc();

        // Simultaneous requests after reset: D wins the first tie.
        do_reset();
        i_dfp_addr = 32'h40; i_dfp_read = 1;
        d_dfp_addr = 32'h80; d_dfp_write = 1; d_dfp_wdata = 256'h1;
        cyc();
        chk("t2_mem_write", mem_write, 1'b1);
        chk("t2_mem_wdata", mem_wdata, 256'h1);
        chk("t2_mem_addr", mem_addr, 32'h80);
        mem_resp = 1;
        #1;
        chk("t2_d_resp", d_dfp_resp, 1'b1);
        chk("t2_i_resp", i_dfp_resp, 1'b0);
        cyc();
        d_dfp_write = 0; mem_resp = 0;
        chk("t2_gap_read", mem_read, 1'b0);
        cyc();
        chk("t2_i_read", mem_read, 1'b1);
        chk("t2_i_addr", mem_addr, 32'h40);
        mem_resp = 1;
        cyc();
        i_dfp_read = 0; mem_resp = 0;
        cyc();

        // Stability while requesters change during a transaction.
        d_dfp_addr = 32'h100; d_dfp_write = 1; d_dfp_wdata = 256'hBEEF;
        cyc();
        d_dfp_addr = 32'h200; i_dfp_addr = 32'h500; i_dfp_read = 1;
        cyc();
        chk("t4_addr_hold1", mem_addr, 32'h100);
        cyc();
        chk("t4_addr_hold2", mem_addr, 32'h100);
        mem_resp = 1;
        cyc();
        d_dfp_write = 0; mem_resp = 0;
        cyc();
        chk("t4_i_addr", mem_addr, 32'h500);
        mem_resp = 1;
        cyc();
        i_dfp_read = 0; mem_resp = 0;
        cyc();

        // Reset mid-transaction, then a stray response in idle.
        i_dfp_addr = 32'h700; i_dfp_read = 1;
        cyc();
        cyc();
        rst = 1;
        cyc();
        rst = 0; i_dfp_read = 0;
        chk("t5_mem_read", mem_read, 1'b0);
        chk("t5_mem_write", mem_write, 1'b0);
        mem_resp = 1;
        #1;
        chk("t5_stray_i", i_dfp_resp, 1'b0);
        chk("t5_stray_d", d_dfp_resp, 1'b0);
        cyc();
        mem_resp = 0;
        cyc();
        chk("t5_still_idle", mem_read | mem_write, 1'b0);

        // Read and write together: write wins.
        i_dfp_addr = 32'h300; i_dfp_read = 1; i_dfp_write = 1; i_dfp_wdata = 256'h33;
        cyc();
        chk("t6_write", mem_write, 1'b1);
        chk("t6_read", mem_read, 1'b0);
        chk("t6_addr", mem_addr, 32'h300);
        mem_resp = 1;
        cyc();
        i_dfp_read = 0; i_dfp_write = 0; mem_resp = 0;
        cyc();

        // Round-robin fairness with both caches always re-requesting.
        do_reset();
        order.delete();
        run_traffic(80, 1'b1, 3);
        chk("rr_count", 32'(order.size() >= 6), 32'd1);
        for (int k = 0; k < 6; k++) begin
            if (k < order.size())
                chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'((k % 2 == 0) ? 1 : 0));
        end

        // Random traffic with spurious idle responses.
        do_reset();
        run_traffic(3000, 1'b0, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
